security_ctrl_nzone: RTL

- Parametrised multi-zone successor to the single door/window alarm FSM.
- Supports N sensor zones with per-zone bypass and instant/delayed classification.
- Adds an exit delay on arming, a timed entry delay, a siren timeout with a silenced alarm-memory state, and a latched record of triggered zones.
- Sits between the board switches/sensors and the siren output and status display driver; the display mux is outside this block.

---
 rtl/security_ctrl_nzone_pkg.sv | 33 +++
 rtl/security_ctrl_nzone_tick_gen.sv | 41 ++++
 rtl/security_ctrl_nzone.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/security_ctrl_nzone_pkg.sv
// Shared definitions for the multi-zone security controller.
//
// Contents:
//   state_t          3-bit controller state, encoded as it appears on STATE.
//   CLK_FREQ_10MS    clocks per 10 ms tick at 125 MHz.
//   DEF_ARM_CODE     default key value that requests arming.
//   DEF_DISARM_CODE  default key value that disarms.
//   max3()           largest of three integers; sizes the delay counter.
package security_pkg;

    typedef enum logic [2:0] {
        S_DISARMED    = 3'd0,
        S_EXIT_DELAY  = 3'd1,
        S_ARMED       = 3'd2,
        S_ENTRY_DELAY = 3'd3,
        S_ALARM       = 3'd4,
        S_SILENCED    = 3'd5
    } state_t;

    localparam int CLK_FREQ_10MS = 125_000_000 / 100;

    localparam logic [1:0] DEF_ARM_CODE    = 2'b11;
    localparam logic [1:0] DEF_DISARM_CODE = 2'b00;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/security_ctrl_nzone_tick_gen.sv
// Free-running tick generator.
//
// TICK is a registered one-cycle pulse.
// The first pulse appears CLK_FREQ cycles after reset is released.
// After that it repeats every CLK_FREQ cycles.
// Nothing but RST restarts it. The display scan logic reuses it as well.
//
// Ports:
//   CLK   in  1  system clock
//   RST   in  1  synchronous active-high reset
//   TICK  out 1  one-cycle pulse every CLK_FREQ clocks
module tick_gen #(
    parameter int CLK_FREQ = 4
) (
    input  logic CLK,
    input  logic RST,
    output logic TICK
);

    localparam int CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_FREQ - 1);

    logic [CW-1:0] cnt;

    // The pulse is registered off the wrap value. The counter reaches LAST
    // after CLK_FREQ-1 edges, so TICK rises on the CLK_FREQ-th edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt  <= '0;
            TICK <= 1'b0;
        end else begin
            TICK <= (cnt == LAST);
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/security_ctrl_nzone.sv
// Multi-zone alarm controller.
//
// Features:
//   - exit delay after arming
//   - timed entry delay for delayed zones
//   - instant zones that go straight to ALARM
//   - siren timeout into a silenced alarm-memory state
//   - latched record of the zones that violated while armed
//
// Ports:
//   CLK          in  1        system clock
//   RST          in  1        synchronous active-high reset
//   KEY          in  KEY_W    key/code switches (level-sensitive)
//   ZONE         in  N_ZONES  sensor inputs, 1 = open
//   BYPASS       in  N_ZONES  1 = ignore that zone
//   ALARM_SIREN  out 1        siren drive
//   STATE        out 3        current state encoding
//   TRIG_ZONE    out N_ZONES  latched violated zones
//   NOT_READY    out 1        unbypassed zone open while disarmed
module security_ctrl_nzone
    import security_pkg::*;
#(
    parameter int                  N_ZONES      = 4,
    parameter int                  KEY_W        = 2,
    parameter logic [KEY_W-1:0]    ARM_CODE     = KEY_W'(DEF_ARM_CODE),
    parameter logic [KEY_W-1:0]    DISARM_CODE  = KEY_W'(DEF_DISARM_CODE),
    parameter logic [N_ZONES-1:0]  INSTANT_MASK = N_ZONES'(1),
    parameter int                  CLK_FREQ     = CLK_FREQ_10MS,
    parameter int                  EXIT_DLY     = 1000,
    parameter int                  ENTRY_DLY    = 500,
    parameter int                  SIREN_DLY    = 6000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [KEY_W-1:0]   KEY,
    input  logic [N_ZONES-1:0] ZONE,
    input  logic [N_ZONES-1:0] BYPASS,
    output logic               ALARM_SIREN,
    output logic [2:0]         STATE,
    output logic [N_ZONES-1:0] TRIG_ZONE,
    output logic               NOT_READY
);

    localparam int MAX_DLY = max3(EXIT_DLY, ENTRY_DLY, SIREN_DLY);
    localparam int CNT_W   = (MAX_DLY > 0) ? $clog2(MAX_DLY + 1) : 1;

    localparam logic [CNT_W-1:0] EXIT_LIM  = CNT_W'(EXIT_DLY);
    localparam logic [CNT_W-1:0] ENTRY_LIM = CNT_W'(ENTRY_DLY);
    localparam logic [CNT_W-1:0] SIREN_LIM = CNT_W'(SIREN_DLY);

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   dly_cnt;
    logic [N_ZONES-1:0] trig_zone;
    logic               tick;

    logic [N_ZONES-1:0] act;
    logic               inst;
    logic               dly;
    logic               new_zone;
    logic               disarm;
    logic               arm_req;
    logic               ready_fault;
    logic               timed;
    logic               monitoring;
    logic               done;

    tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .TICK (tick)
    );

    // Zone qualification is purely combinational.
    // A bypass change therefore takes effect in the same cycle.
    assign act         = ZONE & ~BYPASS;
    assign inst        = |(act & INSTANT_MASK);
    assign dly         = |(act & ~INSTANT_MASK);
    assign new_zone    = |(act & ~trig_zone);
    assign disarm      = (KEY == DISARM_CODE);
    assign arm_req     = (KEY == ARM_CODE);
    assign ready_fault = (state == S_DISARMED) && (|act);

    assign timed = (state == S_EXIT_DELAY) || (state == S_ENTRY_DELAY) ||
                   (state == S_ALARM);

    assign monitoring = (state == S_ARMED) || (state == S_ENTRY_DELAY) ||
                        (state == S_ALARM) || (state == S_SILENCED);

    // Each timed state compares the shared counter against its own limit.
    always_comb begin
        done = 1'b0;
        case (state)
            S_EXIT_DELAY:  done = (dly_cnt == EXIT_LIM);
            S_ENTRY_DELAY: done = (dly_cnt == ENTRY_LIM);
            S_ALARM:       done = (dly_cnt == SIREN_LIM);
            default:       done = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_DISARMED;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Disarm is tested first in every state, so it
    // beats zone events and timeouts arriving in the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            S_DISARMED: begin
                if (arm_req && !ready_fault) next_state = S_EXIT_DELAY;
            end
            S_EXIT_DELAY: begin
                if (disarm)    next_state = S_DISARMED;
                else if (done) next_state = S_ARMED;
            end
            S_ARMED: begin
                if (disarm)    next_state = S_DISARMED;
                else if (inst) next_state = S_ALARM;
                else if (dly)  next_state = S_ENTRY_DELAY;
            end
            S_ENTRY_DELAY: begin
                if (disarm)    next_state = S_DISARMED;
                else if (inst) next_state = S_ALARM;
                else if (done) next_state = S_ALARM;
            end
            S_ALARM: begin
                if (disarm)    next_state = S_DISARMED;
                else if (done) next_state = S_SILENCED;
            end
            S_SILENCED: begin
                if (disarm)        next_state = S_DISARMED;
                else if (new_zone) next_state = S_ALARM;
            end
            default: next_state = S_DISARMED;
        endcase
    end

    // Output decode
    always_comb begin
        ALARM_SIREN = (state == S_ALARM);
        STATE       = state;
        TRIG_ZONE   = trig_zone;
        NOT_READY   = ready_fault;
    end

    // The delay counter restarts on any state change, including a
    // SILENCED->ALARM retrigger, so each timed state starts from zero.
    // The tick generator keeps its own phase and is never realigned.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dly_cnt <= '0;
        end else if ((next_state != state) || !timed) begin
            dly_cnt <= '0;
        end else if (tick) begin
            dly_cnt <= dly_cnt + CNT_W'(1);
        end
    end

    // Triggered zones accumulate while armed or alarming.
    // They persist through disarm as alarm memory.
    // They are cleared only by the next successful arm.
    always_ff @(posedge CLK) begin
        if (RST) begin
            trig_zone <= '0;
        end else if ((state == S_DISARMED) && (next_state == S_EXIT_DELAY)) begin
            trig_zone <= '0;
        end else if (monitoring) begin
            trig_zone <= trig_zone | act;
        end
    end

endmodule
